// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline hazard types: FSM encoding, control-bundle layout and the
// canned control words used by the hazard controller.
package pipeline_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_TIMEOUT  = 2'd2
   } state_t;

   typedef struct packed {
      logic pc_write;
      logic ifid_write;
      logic ifid_flush;
      logic idex_stall;
      logic pipe_hold;
   } ctrl_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // Reset drives NOPs into IF/ID and ID/EX while nothing advances.
   localparam ctrl_t CTRL_RESET    = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1, idex_stall: 1'b1, pipe_hold: 1'b0};
   localparam ctrl_t CTRL_RUN      = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_stall: 1'b0, pipe_hold: 1'b0};
   localparam ctrl_t CTRL_BUBBLE   = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_stall: 1'b1, pipe_hold: 1'b0};
   localparam ctrl_t CTRL_REDIRECT = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, idex_stall: 1'b1, pipe_hold: 1'b0};
   localparam ctrl_t CTRL_FREEZE   = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_stall: 1'b0, pipe_hold: 1'b1};

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use comparator: flags an ID-stage read of the register an EX-stage
// load is about to write. $zero never creates a hazard.
module load_use_detect
   import pipeline_hazard_ctrl_pkg::*;
(
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_use_rs,
   input  logic       id_use_rt,
   input  logic       ex_MemRead,
   input  logic [4:0] ex_Reg_Write_addr,
   output logic       load_use
);

   logic rs_hit;
   logic rt_hit;

   assign rs_hit   = id_use_rs && (id_rs == ex_Reg_Write_addr);
   assign rt_hit   = id_use_rt && (id_rt == ex_Reg_Write_addr);
   assign load_use = ex_MemRead && (ex_Reg_Write_addr != REG_ZERO) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, redirect flushes and
// memory-wait freezing with a timeout, plus saturating event counters.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_use_rs,
   input  logic        id_use_rt,
   input  logic        ex_MemRead,
   input  logic [4:0]  ex_Reg_Write_addr,
   input  logic        ex_redirect,
   input  logic        mem_req,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        ifid_write,
   output logic        ifid_flush,
   output logic        idex_stall,
   output logic        pipe_hold,
   output logic        mem_timeout,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt,
   output state_t      dbg_state
);

   localparam logic [8:0] TO_LIM = 9'(MEM_TIMEOUT);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] wait_cnt;
   logic       load_use;
   logic       mem_stall;
   logic       act_run;
   logic       stall_ev;
   logic       flush_ev;
   ctrl_t      ctrl;

   load_use_detect u_load_use_detect (
      .id_rs             (id_rs),
      .id_rt             (id_rt),
      .id_use_rs         (id_use_rs),
      .id_use_rt         (id_use_rt),
      .ex_MemRead        (ex_MemRead),
      .ex_Reg_Write_addr (ex_Reg_Write_addr),
      .load_use          (load_use)
   );

   // MEM handshake: mem_req marks an access in flight; the access completes in
   // the cycle mem_ready is sampled high. mem_ready low with mem_req high stalls.
   assign mem_stall = mem_req && !mem_ready;
   // A MEM_WAIT cycle that sees mem_ready behaves exactly like a RUN cycle.
   assign act_run   = (state == ST_RUN) || ((state == ST_MEM_WAIT) && mem_ready);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= ST_RUN;
         wait_cnt <= 8'd0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= ((state == ST_MEM_WAIT) && (state_nxt == ST_MEM_WAIT)) ? wait_cnt + 8'd1 : 8'd0;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN:      if (mem_stall) state_nxt = ST_MEM_WAIT;
         ST_MEM_WAIT: begin
            if (mem_ready)                               state_nxt = ST_RUN;
            else if (({1'b0, wait_cnt} + 9'd1) >= TO_LIM) state_nxt = ST_TIMEOUT;
         end
         ST_TIMEOUT:  state_nxt = ST_TIMEOUT;
         default:     state_nxt = ST_RUN;
      endcase
   end

   always_comb begin
      ctrl = CTRL_FREEZE;
      if (!RST_N)               ctrl = CTRL_RESET;
      else if (act_run) begin
         if (mem_stall)         ctrl = CTRL_FREEZE;
         else if (ex_redirect)  ctrl = CTRL_REDIRECT;
         else if (load_use)     ctrl = CTRL_BUBBLE;
         else                   ctrl = CTRL_RUN;
      end
   end

   assign stall_ev = (act_run && !mem_stall && !ex_redirect && load_use) ||
                     ((state == ST_MEM_WAIT) && !mem_ready);
   assign flush_ev = act_run && !mem_stall && ex_redirect;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         stall_cnt <= 16'd0;
         flush_cnt <= 16'd0;
      end else begin
         if (stall_ev) stall_cnt <= sat_inc16(stall_cnt);
         if (flush_ev) flush_cnt <= sat_inc16(flush_cnt);
      end
   end

   assign pc_write    = ctrl.pc_write;
   assign ifid_write  = ctrl.ifid_write;
   assign ifid_flush  = ctrl.ifid_flush;
   assign idex_stall  = ctrl.idex_stall;
   assign pipe_hold   = ctrl.pipe_hold;
   assign mem_timeout = (state == ST_TIMEOUT);
   assign dbg_state   = state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed hazard scenarios followed by
// randomized traffic, all checked against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;
   import pipeline_hazard_ctrl_pkg::*;

   localparam int TO = 4;

   logic        CLK;
   logic        RST_N;
   logic [4:0]  id_rs, id_rt;
   logic        id_use_rs, id_use_rt;
   logic        ex_MemRead;
   logic [4:0]  ex_Reg_Write_addr;
   logic        ex_redirect;
   logic        mem_req, mem_ready;
   logic        pc_write, ifid_write, ifid_flush, idex_stall, pipe_hold;
   logic        mem_timeout;
   logic [15:0] stall_cnt, flush_cnt;
   state_t      dbg_state;

   int n_total = 0;
   int n_bad   = 0;

   // model state
   bit m_wait;
   int m_waited;
   bit m_dead;
   int m_stall;
   int m_flush;

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
      .CLK               (CLK),
      .RST_N             (RST_N),
      .id_rs             (id_rs),
      .id_rt             (id_rt),
      .id_use_rs         (id_use_rs),
      .id_use_rt         (id_use_rt),
      .ex_MemRead        (ex_MemRead),
      .ex_Reg_Write_addr (ex_Reg_Write_addr),
      .ex_redirect       (ex_redirect),
      .mem_req           (mem_req),
      .mem_ready         (mem_ready),
      .pc_write          (pc_write),
      .ifid_write        (ifid_write),
      .ifid_flush        (ifid_flush),
      .idex_stall        (idex_stall),
      .pipe_hold         (pipe_hold),
      .mem_timeout       (mem_timeout),
      .stall_cnt         (stall_cnt),
      .flush_cnt         (flush_cnt),
      .dbg_state         (dbg_state)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit model_lu();
      if (!ex_MemRead || ex_Reg_Write_addr == 5'd0) return 1'b0;
      return (id_use_rs && id_rs == ex_Reg_Write_addr) || (id_use_rt && id_rt == ex_Reg_Write_addr);
   endfunction

   // {pc_write, ifid_write, ifid_flush, idex_stall, pipe_hold}
   function automatic logic [4:0] model_ctrl(input bit lu);
      if (m_dead)                  return 5'b00001;
      if (m_wait && !mem_ready)    return 5'b00001;
      if (mem_req && !mem_ready)   return 5'b00001;
      if (ex_redirect)             return 5'b11110;
      if (lu)                      return 5'b00010;
      return 5'b11000;
   endfunction

   function automatic int inc_sat(input int v);
      return (v >= 65535) ? 65535 : v + 1;
   endfunction

   task automatic model_update(input bit lu);
      if (m_dead) return;
      if (m_wait && !mem_ready) begin
         m_stall = inc_sat(m_stall);
         m_waited++;
         if (m_waited >= TO) begin
            m_dead = 1'b1;
            m_wait = 1'b0;
         end
      end else begin
         m_wait = 1'b0;
         if (mem_req && !mem_ready) begin
            m_wait   = 1'b1;
            m_waited = 0;
         end else if (ex_redirect) m_flush = inc_sat(m_flush);
         else if (lu)              m_stall = inc_sat(m_stall);
      end
   endtask

   task automatic cycle();
      bit lu;
      state_t es;
      @(negedge CLK);
      lu = model_lu();
      es = m_dead ? ST_TIMEOUT : (m_wait ? ST_MEM_WAIT : ST_RUN);
      chk("ctrl", {27'd0, pc_write, ifid_write, ifid_flush, idex_stall, pipe_hold}, {27'd0, model_ctrl(lu)});
      chk("mem_timeout", {31'd0, mem_timeout}, {31'd0, m_dead});
      chk("stall_cnt", {16'd0, stall_cnt}, 32'(m_stall));
      chk("flush_cnt", {16'd0, flush_cnt}, 32'(m_flush));
      chk("state", {30'd0, dbg_state}, {30'd0, es});
      @(posedge CLK);
      model_update(lu);
      #1;
   endtask

   task automatic do_reset();
      RST_N = 1'b0;
      #1;
      chk("rst_ctrl", {27'd0, pc_write, ifid_write, ifid_flush, idex_stall, pipe_hold}, 32'b00110);
      chk("rst_timeout", {31'd0, mem_timeout}, 32'd0);
      chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
      chk("rst_flush_cnt", {16'd0, flush_cnt}, 32'd0);
      chk("rst_state", {30'd0, dbg_state}, {30'd0, ST_RUN});
      m_wait = 1'b0; m_waited = 0; m_dead = 1'b0; m_stall = 0; m_flush = 0;
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
   endtask

   task automatic idle();
      id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
      ex_MemRead = 1'b0; ex_Reg_Write_addr = 5'd0; ex_redirect = 1'b0;
      mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic load_use_inputs(input logic [4:0] dst, input logic [4:0] rs);
      ex_MemRead = 1'b1; ex_Reg_Write_addr = dst; id_rs = rs; id_use_rs = 1'b1;
   endtask

   initial begin
      RST_N = 1'b0;
      idle();
      #3;
      do_reset();

      // lw $8 in EX, add reading $8 as rs in ID: one bubble
      idle(); cycle();
      load_use_inputs(5'd8, 5'd8); cycle();
      idle(); cycle();
      chk("lu_stall_once", {16'd0, stall_cnt}, 32'd1);

      // load to $0 never stalls
      load_use_inputs(5'd0, 5'd0); id_rt = 5'd0; id_use_rt = 1'b1; cycle();
      // rt-side hit
      idle(); ex_MemRead = 1'b1; ex_Reg_Write_addr = 5'd5; id_rt = 5'd5; id_use_rt = 1'b1; cycle();
      // address matches but not read
      id_use_rt = 1'b0; cycle();

      // redirect wins over load-use
      idle(); load_use_inputs(5'd9, 5'd9); ex_redirect = 1'b1; cycle();
      idle(); cycle();

      // memory wait: ready low in the request cycle and 3 wait cycles
      mem_req = 1'b1;
      for (int i = 0; i < 4; i++) cycle();
      mem_ready = 1'b1; cycle();
      idle(); cycle();

      // memory wait ending with a load-use in the ready cycle
      mem_req = 1'b1; cycle(); cycle();
      mem_ready = 1'b1; load_use_inputs(5'd3, 5'd3); cycle();
      idle(); cycle();

      // timeout: ready never rises
      mem_req = 1'b1; load_use_inputs(5'd4, 5'd4); ex_redirect = 1'b1;
      for (int i = 0; i < 9; i++) cycle();
      chk("timeout_sticky", {31'd0, mem_timeout}, 32'd1);
      idle(); do_reset();
      idle(); cycle();

      // randomized traffic with occasional mid-operation resets
      for (int i = 0; i < 800; i++) begin
         id_rs             = 5'($urandom_range(0, 3));
         id_rt             = 5'($urandom_range(0, 3));
         id_use_rs         = 1'($urandom_range(0, 1));
         id_use_rt         = 1'($urandom_range(0, 1));
         ex_MemRead        = ($urandom_range(0, 2) != 0);
         ex_Reg_Write_addr = 5'($urandom_range(0, 3));
         ex_redirect       = ($urandom_range(0, 4) == 0);
         mem_req           = ($urandom_range(0, 5) == 0) || m_wait;
         mem_ready         = ($urandom_range(0, 2) == 0);
         if ((m_dead && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0) do_reset();
         else cycle();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have port CLK, input, 1, the single pipeline clock; all state changes on its rising edge.
REQ-002 SHALL have port RST_N, input, 1, reset that is asynchronous and active-low.
REQ-003 SHALL have port id_rs / id_rt, input, 5 each, ID-stage source register addresses.
REQ-004 SHALL have port id_use_rs / id_use_rt, input, 1 each, ID instruction actually reads rs / rt.
REQ-005 SHALL have port ex_MemRead, input, 1, EX-stage instruction is a load.
REQ-006 SHALL have port ex_Reg_Write_addr, input, 5, EX-stage destination register.
REQ-007 SHALL have port ex_redirect, input, 1, EX resolved taken branch or jump (Branch taken or JToPC).
REQ-008 SHALL have port mem_req / mem_ready, input, 1 each, MEM-stage access request and completion handshake.
REQ-009 SHALL have port pc_write / ifid_write, output, 1 each, enable PC and IF/ID register update.
REQ-010 SHALL have port ifid_flush, output, 1, IF/ID loads NOP.
REQ-011 SHALL have port idex_stall, output, 1, drives ID/EX buffer stall input (NOP insert).
REQ-012 SHALL have port pipe_hold, output, 1, freezes ID/EX, EX/MEM, MEM/WB registers.
REQ-013 SHALL have port mem_timeout, output, 1, sticky memory-wait timeout flag.
REQ-014 SHALL have port stall_cnt / flush_cnt, output, 16 each, saturating event counters.
REQ-015 SHALL have parameter MEM_TIMEOUT, default 255, maximum MEM_WAIT cycles before timeout.

Function
REQ-016 SHALL implement FSM states RUN, MEM_WAIT, TIMEOUT.
REQ-017 SHALL define load-use hazard: ex_MemRead=1, ex_Reg_Write_addr!=0, and the address equals id_rs with id_use_rs=1 or equals id_rt with id_use_rt=1.
REQ-018 SHALL, in RUN with load-use and no redirect, drive pc_write=0, ifid_write=0, idex_stall=1 that cycle only (one bubble, zero extra latency).
REQ-019 SHALL, in RUN with ex_redirect=1, drive ifid_flush=1 and idex_stall=1 with pc_write=1, ifid_write=1 that cycle; redirect overrides load-use.
REQ-020 SHALL, in RUN with mem_req=1 and mem_ready=0, transition to MEM_WAIT at the next edge and assert pipe_hold=1, pc_write=0, ifid_write=0 combinationally that cycle; this overrides redirect and load-use.
REQ-021 SHALL in MEM_WAIT hold pc_write=0, ifid_write=0, pipe_hold=1, ifid_flush=0, idex_stall=0 and count wait cycles in an 8-bit counter cleared on entry.
REQ-022 SHALL leave MEM_WAIT to RUN at the edge where mem_ready=1; that cycle outputs equal RUN outputs for the current inputs.
REQ-023 SHALL enter TIMEOUT when the wait counter reaches MEM_TIMEOUT with mem_ready=0; TIMEOUT sets mem_timeout=1, keeps full freeze, exits only by reset.
REQ-024 SHALL, with no hazard in RUN, drive pc_write=1, ifid_write=1, all others 0.
REQ-025 SHALL increment stall_cnt once per load-use bubble cycle and per MEM_WAIT cycle; flush_cnt once per redirect cycle; both saturate at 16'hFFFF.
REQ-026 SHALL ignore id_use_* for register 0 (no hazard on $zero).

Reset
REQ-027 SHALL on RST_N=0 immediately force state RUN, wait counter 0, mem_timeout=0, stall_cnt=0, flush_cnt=0.
REQ-028 SHALL, during reset, drive pc_write=0, ifid_write=0, idex_stall=1, ifid_flush=1, pipe_hold=0.
REQ-029 SHALL abort MEM_WAIT or TIMEOUT on reset assertion mid-operation with no residual hold.

Structure
REQ-030 SHALL place state encoding (2-bit) and the NOP/default-control constants in the shared pipeline package.
REQ-031 SHALL isolate the comparator logic in one sub-module, load_use_detect.

Verification
REQ-032 SHALL cover: EX lw to $8, ID add reading $8 as rs -> exactly one cycle pc_write=0, idex_stall=1, stall_cnt 0->1.
REQ-033 SHALL cover: EX lw to $0, ID reads $0 -> no stall.
REQ-034 SHALL cover: ex_redirect=1 together with load-use -> ifid_flush=1, idex_stall=1, pc_write=1, flush_cnt+1, stall_cnt unchanged.
REQ-035 SHALL cover: mem_req=1, mem_ready low 3 cycles -> pipe_hold=1 for 4 cycles, RUN on 4th edge, stall_cnt=3.
REQ-036 SHALL cover: MEM_TIMEOUT=4, mem_ready never rises -> mem_timeout=1 after 5 hold cycles; RST_N pulse low clears all outputs to reset values.
